mux8x1_scan_ctrl: RTL and testbench
===================================

MUX8X1_SCAN_CTRL -- requirements
Module: mux8x1_scan_ctrl

Interface
REQ-001 Parameter: SETTLE, default 1, settle cycles inserted after each select change before sampling (legal 0..15).
REQ-002 Port: clk  input  1  single system clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  request one full 8-channel scan; sampled only in IDLE.
REQ-005 Port: abort  input  1  cancel scan in progress.
REQ-006 Port: mux_en  output  1  drives the 8x1 mux EN.
REQ-007 Port: mux_sel  output  4  drives the 8x1 mux A; bit 3 always 0.
REQ-008 Port: mux_q  input  1  the 8x1 mux Q.
REQ-009 Port: busy  output  1  high in any state other than IDLE.
REQ-010 Port: done  output  1  one-cycle pulse, scan result valid.
REQ-011 Port: data  output  8  last completed scan; data[i] = mux_q sampled with mux_sel=i.
REQ-012 Port: parity  output  1  XOR of data bits (present only with MUX_SCAN_PARITY_EN).

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE; all outputs registered.
REQ-014 IDLE: mux_en=0, mux_sel=0, busy=0, done=0; start=1 at an edge -> channel index 0, mux_en=1, next state SETTLE (SAMPLE directly if SETTLE=0).
REQ-015 SETTLE: 4-bit counter runs SETTLE cycles with mux_sel held; on expiry -> SAMPLE.
REQ-016 SAMPLE: lasts exactly one cycle; mux_q captured into shadow bit [index] at the closing edge.
REQ-017 After SAMPLE: index<7 -> index+1, mux_sel updated same edge, -> SETTLE (or SAMPLE if SETTLE=0); index=7 -> DONE.
REQ-018 Entry into DONE SHALL copy the shadow register to data in the same edge; data SHALL be otherwise stable.
REQ-019 DONE: done=1, mux_en=0, mux_sel=0, lasts one cycle, -> IDLE unconditionally.
REQ-020 Latency: done high in the cycle beginning 8*(SETTLE+1) edges after the start-accept edge (SETTLE=1 -> 16).
REQ-021 start while busy (incl. DONE cycle) SHALL be ignored, not queued; back-to-back scans need start in IDLE, so minimum period 8*(SETTLE+1)+2 cycles.
REQ-022 abort=1 in SETTLE or SAMPLE -> IDLE at next edge, no done, data unchanged, shadow discarded; abort has priority over SAMPLE capture and over start.
REQ-023 abort in IDLE or DONE has no effect; DONE still completes and pulses done.
REQ-024 mux_sel SHALL never exceed 7; index wraps to 0 only via DONE/IDLE.

Reset
REQ-025 rst_n=0 SHALL immediately (no clock) force IDLE, mux_en=0, mux_sel=0, busy=0, done=0, data=8'h00, shadow=0, counter=0, parity=0.
REQ-026 Reset asserted mid-scan SHALL discard the scan; after release the block waits for a new start.

Configuration
REQ-027 Macro MUX_SCAN_PARITY_EN defined: parity port exists, register updated to ^shadow on the same edge as data, reset 0.
REQ-028 Macro undefined: parity port and logic absent; all other behaviour identical.

Verification (bench models the 8x1 mux: Q = EN ? X[A[2:0]] : 0)
REQ-029 SETTLE=1, X=8'hAA, start pulse -> mux_sel steps 0..7 every 2 cycles, done at edge 16, data=8'hAA, parity=0 (macro on).
REQ-030 SETTLE=0, X=8'h5B -> done at edge 8 after accept, data=8'h5B, parity=1; mux_sel changes every cycle.
REQ-031 Scan with X=8'h0F completes, then start held high during 2nd scan with X=8'hF0 -> second result data=8'hF0, exactly one done per scan, no extra scan from held start.
REQ-032 abort asserted while mux_sel=3 -> busy low next cycle, no done, data keeps previous 8'h0F.
REQ-033 rst_n pulled low mid-scan (mux_sel=5) asynchronously -> outputs reset values immediately, data=8'h00; new start with X=8'h81 -> data=8'h81.
REQ-034 Throughout all scans: mux_en=0 whenever busy=0, and mux_sel[3]=0 always (assertion).

Source files
------------

// File: rtl/mux8x1_scan_ctrl.sv
// mux8x1_scan_ctrl: scans the eight channels of an external 8x1 mux into a byte, with settle delay per channel.
// Optional parity output of the scanned byte is enabled by defining MUX_SCAN_PARITY_EN.
module mux8x1_scan_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       mux_en,
    output logic [3:0] mux_sel,
    input  logic       mux_q,
    output logic       busy,
    output logic       done,
    output logic [7:0] data
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic       parity
`endif
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
    // With no settle time each new channel is sampled on the very next cycle
    localparam state_t AFTER_SEL = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
    localparam logic [3:0] LAST = 4'(SETTLE > 0 ? SETTLE - 1 : 0);
    state_t     state;
    logic [3:0] cnt;
    logic [2:0] idx;
    logic [7:0] shadow;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            shadow  <= '0;
            mux_en  <= 1'b0;
            mux_sel <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            data    <= '0;
`ifdef MUX_SCAN_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    state   <= AFTER_SEL;
                    idx     <= '0;
                    cnt     <= '0;
                    shadow  <= '0;
                    mux_en  <= 1'b1;
                    mux_sel <= '0;
                    busy    <= 1'b1;
                end
                ST_SETTLE: if (abort) begin
                    state   <= ST_IDLE;
                    idx     <= '0;
                    cnt     <= '0;
                    shadow  <= '0;
                    mux_en  <= 1'b0;
                    mux_sel <= '0;
                    busy    <= 1'b0;
                end else if (cnt == LAST) begin
                    state <= ST_SAMPLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                ST_SAMPLE: if (abort) begin
                    state   <= ST_IDLE;
                    idx     <= '0;
                    cnt     <= '0;
                    shadow  <= '0;
                    mux_en  <= 1'b0;
                    mux_sel <= '0;
                    busy    <= 1'b0;
                end else if (idx == 3'd7) begin
                    // Last bit bypasses the shadow so data is complete on DONE entry
                    state     <= ST_DONE;
                    shadow[7] <= mux_q;
                    data      <= {mux_q, shadow[6:0]};
`ifdef MUX_SCAN_PARITY_EN
                    parity    <= ^{mux_q, shadow[6:0]};
`endif
                    idx       <= '0;
                    mux_en    <= 1'b0;
                    mux_sel   <= '0;
                    done      <= 1'b1;
                end else begin
                    state       <= AFTER_SEL;
                    shadow[idx] <= mux_q;
                    idx         <= idx + 3'd1;
                    mux_sel     <= {1'b0, idx + 3'd1};
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux8x1_scan_ctrl.sv
// tb_mux8x1_scan_ctrl: random and directed scans of two instances (SETTLE=1 and SETTLE=0) against a timing model.
module tb_mux8x1_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start [2];
    logic       abort [2];
    logic       en    [2];
    logic       q     [2];
    logic       busy  [2];
    logic       done  [2];
    logic [3:0] sel   [2];
    logic [7:0] data  [2];
    logic [7:0] x     [2];
    logic [7:0] exp_data [2];
`ifdef MUX_SCAN_PARITY_EN
    logic       par   [2];
`endif
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign q[0] = en[0] ? x[0][sel[0][2:0]] : 1'b0;
    assign q[1] = en[1] ? x[1][sel[1][2:0]] : 1'b0;

    mux8x1_scan_ctrl #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .mux_en(en[0]), .mux_sel(sel[0]), .mux_q(q[0]),
        .busy(busy[0]), .done(done[0]), .data(data[0])
`ifdef MUX_SCAN_PARITY_EN
        , .parity(par[0])
`endif
    );

    mux8x1_scan_ctrl #(.SETTLE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .mux_en(en[1]), .mux_sel(sel[1]), .mux_q(q[1]),
        .busy(busy[1]), .done(done[1]), .data(data[1])
`ifdef MUX_SCAN_PARITY_EN
        , .parity(par[1])
`endif
    );

    always @(negedge clk) begin
        assert (busy[0] || !en[0]) else $error("en high while idle (SETTLE=1)");
        assert (busy[1] || !en[1]) else $error("en high while idle (SETTLE=0)");
        assert (!sel[0][3]) else $error("sel[3] set (SETTLE=1)");
        assert (!sel[1][3]) else $error("sel[3] set (SETTLE=0)");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    task automatic chk_idle_reset(input int i);
        chk("rst_busy", busy[i], 0);
        chk("rst_en", en[i], 0);
        chk("rst_sel", sel[i], 0);
        chk("rst_done", done[i], 0);
        chk("rst_data", data[i], 0);
`ifdef MUX_SCAN_PARITY_EN
        chk("rst_parity", par[i], 0);
`endif
    endtask

    // ab_k / rst_k: cycle offset after accept at which to abort / reset (-1 = never)
    task automatic run_scan(input int i, input logic [7:0] xv, input int ab_k, input bit hold, input int rst_k);
        int s;
        int n;
        s = settle_of(i);
        n = 8 * (s + 1);
        x[i] = xv;
        start[i] = 1'b1;
        tick();
        if (!hold) start[i] = 1'b0;
        for (int k = 0; k < n; k++) begin
            chk("sel", sel[i], k / (s + 1));
            chk("busy", busy[i], 1);
            chk("en", en[i], 1);
            chk("done_early", done[i], 0);
            if (k == ab_k) begin
                abort[i] = 1'b1;
                tick();
                abort[i] = 1'b0;
                start[i] = 1'b0;
                chk("abort_busy", busy[i], 0);
                chk("abort_done", done[i], 0);
                chk("abort_sel", sel[i], 0);
                chk("abort_data", data[i], exp_data[i]);
                tick();
                chk("abort_no_done", done[i], 0);
                return;
            end
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                exp_data[0] = 8'h00;
                exp_data[1] = 8'h00;
                start[i] = 1'b0;
                chk_idle_reset(i);
                @(negedge clk);
                rst_n = 1'b1;
                tick();
                tick();
                chk("post_rst_busy", busy[i], 0);
                return;
            end
            tick();
        end
        exp_data[i] = xv;
        chk("done", done[i], 1);
        chk("data", data[i], exp_data[i]);
        chk("done_busy", busy[i], 1);
        chk("done_en", en[i], 0);
        chk("done_sel", sel[i], 0);
`ifdef MUX_SCAN_PARITY_EN
        chk("parity", par[i], ^xv);
`endif
        tick();
        start[i] = 1'b0;
        chk("done_pulse", done[i], 0);
        chk("idle_busy", busy[i], 0);
        tick();
        chk("no_requeue", busy[i], 0);
        chk("data_stable", data[i], exp_data[i]);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            abort[i] = 1'b0;
            x[i] = 8'h00;
            exp_data[i] = 8'h00;
        end
        #12;
        chk_idle_reset(0);
        chk_idle_reset(1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_scan(0, 8'hAA, -1, 1'b0, -1);
        run_scan(1, 8'h5B, -1, 1'b0, -1);
        run_scan(0, 8'h0F, -1, 1'b0, -1);
        run_scan(0, 8'h3C, 3 * 2, 1'b0, -1);
        chk("abort_keeps_0f", data[0], 8'h0F);
        run_scan(0, 8'hF0, -1, 1'b1, -1);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("idle_abort", busy[0], 0);
        run_scan(0, 8'h77, -1, 1'b0, 5 * 2);
        chk("rst_data_other", data[1], 0);
        run_scan(0, 8'h81, -1, 1'b0, -1);
        run_scan(1, 8'hC3, 5, 1'b0, -1);
        for (int t = 0; t < 24; t++) begin
            int i;
            int n;
            int ab;
            i = int'($urandom_range(0, 1));
            n = 8 * (settle_of(i) + 1);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_scan(i, 8'($urandom), ab, 1'($urandom_range(0, 1)), -1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
